fadd_sched: RTL and testbench

FADD_SCHED -- requirements
Module: fadd_sched

---
 rtl/fadd_sched.sv | 253 +++++++++++++++++++++++++
 tb/tb_fadd_sched.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fadd_sched.sv
// fadd_sched: shares one pipelined FP add/sub unit between two requesters.
// Per-requester credits (max 2 in flight) gate issue so the 2-entry result
// FIFOs can never overflow; a {valid,id} tag pipe of depth LAT steers fu_y.
//
// Parameters:
//   LAT            adder latency in cycles (1..4)
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   reqN_*         issue port N: valid/ready handshake, sub, operands x1/x2
//   rspN_*         result port N: valid/ready handshake, result y
//   fu_valid/x1/x2 issue to the shared adder (x2 sign flipped for sub)
//   fu_y           adder result, valid LAT cycles after issue
//   busy           some accepted op is not yet consumed
// Build option:
//   FADD_SCHED_RR_EN  round-robin arbitration (default: fixed, req0 first)

module fadd_sched #(
    parameter int LAT = 1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_sub,
    input  logic [31:0] req0_x1,
    input  logic [31:0] req0_x2,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_sub,
    input  logic [31:0] req1_x1,
    input  logic [31:0] req1_x2,

    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_y,

    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_y,

    output logic        fu_valid,
    output logic [31:0] fu_x1,
    output logic [31:0] fu_x2,
    input  logic [31:0] fu_y,

    output logic        busy
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]     cnt_q  [2];
    logic [1:0]     cnt_d  [2];

    logic [31:0]    mem_q  [2][2];
    logic [31:0]    mem_d  [2][2];
    logic [1:0]     fcnt_q [2];
    logic [1:0]     fcnt_d [2];
    logic [1:0]     wp_q;
    logic [1:0]     wp_d;
    logic [1:0]     rp_q;
    logic [1:0]     rp_d;

    logic [LAT-1:0] tv_q;
    logic [LAT-1:0] tv_d;
    logic [LAT-1:0] tid_q;
    logic [LAT-1:0] tid_d;

    logic           busy_q;
    logic           busy_d;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic [1:0] req_valid;
    logic [1:0] rsp_ready;
    logic [1:0] elig;
    logic [1:0] gnt;
    logic [1:0] fire;
    logic [1:0] pop;
    logic [1:0] wr;
    logic [1:0] nonempty;

    assign req_valid = {req1_valid, req0_valid};
    assign rsp_ready = {rsp1_ready, rsp0_ready};

    // Eligibility looks only at registered credits: a pop in this cycle
    // frees the credit for the next cycle, keeping ready off the pop path.
    always_comb begin
        elig = 2'b00;
        for (int n = 0; n < 2; n++) begin
            elig[n] = ~rst & req_valid[n] & (cnt_q[n] < 2'd2);
        end
    end

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
`ifdef FADD_SCHED_RR_EN
    // ptr_q names the requester that wins the next tie.
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt   = elig;
        ptr_d = ptr_q;
        if (elig == 2'b11) begin
            gnt = ptr_q ? 2'b10 : 2'b01;
        end
        if (gnt[0]) begin
            ptr_d = 1'b1;
        end else if (gnt[1]) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        gnt = 2'b00;
        if (elig[0]) begin
            gnt = 2'b01;
        end else if (elig[1]) begin
            gnt = 2'b10;
        end
    end
`endif

    assign fire       = gnt & req_valid;
    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    // ------------------------------------------------------------------
    // Adder issue: subtraction is an add with the x2 sign bit flipped
    // ------------------------------------------------------------------
    always_comb begin
        fu_valid = |gnt;
        fu_x1    = 32'd0;
        fu_x2    = 32'd0;
        if (gnt[0]) begin
            fu_x1 = req0_x1;
            fu_x2 = {req0_x2[31] ^ req0_sub, req0_x2[30:0]};
        end else if (gnt[1]) begin
            fu_x1 = req1_x1;
            fu_x2 = {req1_x2[31] ^ req1_sub, req1_x2[30:0]};
        end
    end

    // ------------------------------------------------------------------
    // Tag pipe: stage LAT-1 lines up with fu_y for the op it belongs to
    // ------------------------------------------------------------------
    always_comb begin
        tv_d     = tv_q;
        tid_d    = tid_q;
        tv_d[0]  = |fire;
        tid_d[0] = fire[1];
        for (int k = 1; k < LAT; k++) begin
            tv_d[k]  = tv_q[k-1];
            tid_d[k] = tid_q[k-1];
        end
    end

    assign wr[0] = tv_q[LAT-1] & ~tid_q[LAT-1];
    assign wr[1] = tv_q[LAT-1] &  tid_q[LAT-1];

    // ------------------------------------------------------------------
    // Result FIFOs and credit counters
    // ------------------------------------------------------------------
    always_comb begin
        nonempty = 2'b00;
        pop      = 2'b00;
        for (int n = 0; n < 2; n++) begin
            nonempty[n] = (fcnt_q[n] != 2'd0);
            pop[n]      = nonempty[n] & rsp_ready[n];
        end
    end

    always_comb begin
        mem_d  = mem_q;
        fcnt_d = fcnt_q;
        cnt_d  = cnt_q;
        wp_d   = wp_q;
        rp_d   = rp_q;
        for (int n = 0; n < 2; n++) begin
            if (wr[n]) begin
                mem_d[n][wp_q[n]] = fu_y;
                wp_d[n]           = ~wp_q[n];
            end
            if (pop[n]) begin
                rp_d[n] = ~rp_q[n];
            end
            case ({wr[n], pop[n]})
                2'b10:   fcnt_d[n] = fcnt_q[n] + 2'd1;
                2'b01:   fcnt_d[n] = fcnt_q[n] - 2'd1;
                default: fcnt_d[n] = fcnt_q[n];
            endcase
            case ({fire[n], pop[n]})
                2'b10:   cnt_d[n] = cnt_q[n] + 2'd1;
                2'b01:   cnt_d[n] = cnt_q[n] - 2'd1;
                default: cnt_d[n] = cnt_q[n];
            endcase
        end
    end

    // busy is registered from next-state credits so it tracks cnt_q exactly.
    assign busy_d = (cnt_d[0] != 2'd0) | (cnt_d[1] != 2'd0);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < 2; n++) begin
                cnt_q[n]     <= 2'd0;
                fcnt_q[n]    <= 2'd0;
                mem_q[n][0]  <= 32'd0;
                mem_q[n][1]  <= 32'd0;
            end
            wp_q   <= 2'b00;
            rp_q   <= 2'b00;
            tv_q   <= '0;
            tid_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            fcnt_q <= fcnt_d;
            mem_q  <= mem_d;
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            tv_q   <= tv_d;
            tid_q  <= tid_d;
            busy_q <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rsp0_valid = nonempty[0];
    assign rsp1_valid = nonempty[1];
    assign rsp0_y     = nonempty[0] ? mem_q[0][rp_q[0]] : 32'd0;
    assign rsp1_y     = nonempty[1] ? mem_q[1][rp_q[1]] : 32'd0;
    assign busy       = busy_q;

endmodule

// File: tb/tb_fadd_sched.sv
// tb_fadd_sched: directed checks of fadd_sched with LAT=1.
// A behavioural adder returns hand-computed FP sums for known operands.

module tb_fadd_sched;

    logic        clk;
    logic        rst;
    logic        req0_valid, req0_ready, req0_sub;
    logic [31:0] req0_x1, req0_x2;
    logic        req1_valid, req1_ready, req1_sub;
    logic [31:0] req1_x1, req1_x2;
    logic        rsp0_valid, rsp0_ready;
    logic [31:0] rsp0_y;
    logic        rsp1_valid, rsp1_ready;
    logic [31:0] rsp1_y;
    logic        fu_valid;
    logic [31:0] fu_x1, fu_x2, fu_y;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    fadd_sched #(.LAT(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_sub   (req0_sub),
        .req0_x1    (req0_x1),
        .req0_x2    (req0_x2),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_sub   (req1_sub),
        .req1_x1    (req1_x1),
        .req1_x2    (req1_x2),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_y     (rsp0_y),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_y     (rsp1_y),
        .fu_valid   (fu_valid),
        .fu_x1      (fu_x1),
        .fu_x2      (fu_x2),
        .fu_y       (fu_y),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] fadd_model(input logic [31:0] a,
                                               input logic [31:0] b);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        if (a == 32'h3F80_0000 && b == 32'hC000_0000) return 32'hBF80_0000;
        return a + b;
    endfunction

    // One-cycle adder model (LAT=1).
    always @(posedge clk) fu_y <= fadd_model(fu_x1, fu_x2);

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int n, input logic v, input logic s,
                       input logic [31:0] a, input logic [31:0] b);
        if (n == 0) begin
            req0_valid = v; req0_sub = s; req0_x1 = a; req0_x2 = b;
        end else begin
            req1_valid = v; req1_sub = s; req1_x1 = a; req1_x2 = b;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    // Single issue on requester n, response expected two cycles later.
    task automatic single_op(input int n, input logic s,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] ex2, input logic [31:0] ey);
        drv(n, 1'b1, s, a, b);
        #1;
        chk("so_ready", (n == 0) ? req0_ready : req1_ready, 1);
        chk("so_fu_valid", fu_valid, 1);
        chk("so_fu_x1", fu_x1, a);
        chk("so_fu_x2", fu_x2, ex2);
        tick();
        drv(n, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        chk("so_rsp_early", (n == 0) ? rsp0_valid : rsp1_valid, 0);
        chk("so_busy", busy, 1);
        tick();
        chk("so_rsp_valid", (n == 0) ? rsp0_valid : rsp1_valid, 1);
        chk("so_rsp_y", (n == 0) ? rsp0_y : rsp1_y, ey);
        chk("so_other_rsp", (n == 0) ? rsp1_valid : rsp0_valid, 0);
        tick();
        chk("so_rsp_done", (n == 0) ? rsp0_valid : rsp1_valid, 0);
        chk("so_busy_done", busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        drv(0, 1'b1, 1'b0, 32'h1, 32'h2);
        drv(1, 1'b1, 1'b0, 32'h3, 32'h4);

        // Reset: ready and fu_valid held low, outputs cleared.
        tick();
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        chk("rst_fu_valid", fu_valid, 0);
        tick();
        rst = 1'b0;
        drv(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drv(1, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        chk("rst_rsp0_valid", rsp0_valid, 0);
        chk("rst_rsp0_y", rsp0_y, 0);
        chk("rst_rsp1_valid", rsp1_valid, 0);
        chk("rst_rsp1_y", rsp1_y, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fu_x1", fu_x1, 0);
        chk("rst_fu_x2", fu_x2, 0);

        // 1.0 + 2.0 = 3.0, then 1.0 - 2.0 = -1.0.
        single_op(0, 1'b0, 32'h3F80_0000, 32'h4000_0000,
                  32'h4000_0000, 32'h4040_0000);
        single_op(0, 1'b1, 32'h3F80_0000, 32'h4000_0000,
                  32'hC000_0000, 32'hBF80_0000);

        // Arbitration with both requesters valid, from a fresh reset.
        do_reset();
        drv(0, 1'b1, 1'b0, 32'h1111_1111, 32'h2222_2222);
        drv(1, 1'b1, 1'b1, 32'h3333_3333, 32'h4444_4444);
`ifdef FADD_SCHED_RR_EN
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_req0_ready", req0_ready, (i % 2 == 0) ? 1 : 0);
            chk("rr_req1_ready", req1_ready, (i % 2 == 0) ? 0 : 1);
            chk("rr_fu_x1", fu_x1,
                (i % 2 == 0) ? 32'h1111_1111 : 32'h3333_3333);
            tick();
        end
`else
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("fp_req0_ready", req0_ready, 1);
            chk("fp_req1_ready", req1_ready, 0);
            chk("fp_fu_x1", fu_x1, 32'h1111_1111);
            tick();
        end
`endif
        drv(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drv(1, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 4; i++) tick();
        chk("arb_drain_busy", busy, 0);

        // Credit backpressure on requester 0.
        rsp0_ready = 1'b0;
        drv(0, 1'b1, 1'b0, 32'h100, 32'h1);
        #1;
        chk("bp_c0_ready", req0_ready, 1);
        tick();
        drv(0, 1'b1, 1'b0, 32'h200, 32'h2);
        #1;
        chk("bp_c1_ready", req0_ready, 1);
        tick();
        drv(0, 1'b1, 1'b0, 32'h300, 32'h3);
        #1;
        chk("bp_c2_ready", req0_ready, 0);
        chk("bp_c2_rsp_valid", rsp0_valid, 1);
        chk("bp_c2_rsp_y", rsp0_y, 32'h101);
        tick();
        chk("bp_c3_ready", req0_ready, 0);
        tick();
        rsp0_ready = 1'b1;
        #1;
        chk("bp_pop_ready", req0_ready, 0);
        chk("bp_pop_y", rsp0_y, 32'h101);
        tick();
        rsp0_ready = 1'b0;
        #1;
        chk("bp_c5_ready", req0_ready, 1);
        chk("bp_c5_fu_x1", fu_x1, 32'h300);
        chk("bp_c5_rsp_y", rsp0_y, 32'h202);
        tick();
        drv(0, 1'b1, 1'b0, 32'h400, 32'h4);
        #1;
        chk("bp_c6_ready", req0_ready, 0);
        chk("bp_c6_busy", busy, 1);
        tick();
        drv(0, 1'b0, 1'b0, 32'd0, 32'd0);
        rsp0_ready = 1'b1;
        #1;
        chk("bp_c7_valid", rsp0_valid, 1);
        chk("bp_c7_y", rsp0_y, 32'h202);
        tick();
        chk("bp_c8_y", rsp0_y, 32'h303);
        tick();
        chk("bp_c9_valid", rsp0_valid, 0);
        chk("bp_c9_busy", busy, 0);

        // Reset in the cycle after an issue drops that op.
        drv(1, 1'b1, 1'b0, 32'h500, 32'h5);
        #1;
        chk("mr_issue_ready", req1_ready, 1);
        tick();
        rst = 1'b1;
        #1;
        chk("mr_rst_ready", req1_ready, 0);
        tick();
        rst = 1'b0;
        drv(1, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("mr_rsp1_valid", rsp1_valid, 0);
            chk("mr_busy", busy, 0);
            tick();
        end

        // Requester 1 result routing: 1.0 - 2.0 = -1.0.
        single_op(1, 1'b1, 32'h3F80_0000, 32'h4000_0000,
                  32'hC000_0000, 32'hBF80_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
